intt_seq_ctrl: RTL and testbench
================================

INTT_SEQ_CTRL -- requirements
Module: intt_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 24, coefficient width.
REQ-002 Parameter N, default 256, coefficients per polynomial; address width 8.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request one load/INTT/unload job; sampled in IDLE only.
REQ-006 busy  out  1  high in every state except IDLE.
REQ-007 done  out  1  one-cycle pulse after the last output word is accepted.
REQ-008 in_valid / in_ready  in / out  1 each  load handshake.
REQ-009 in_data  in  WIDTH  load coefficient, natural order, index 0 first.
REQ-010 out_valid / out_ready  out / in  1 each  unload handshake.
REQ-011 out_data  out  WIDTH  result coefficient, index 0 first.
REQ-012 core_start / core_done  out / in  1 each  INTT core control.
REQ-013 core_addr_a, core_addr_b  in  8 each  core RAM addresses.
REQ-014 core_we_a, core_we_b  in  1 each  core write enables.
REQ-015 core_wdata_a, core_wdata_b  in  WIDTH each  core write data.
REQ-016 ram_addr_a, ram_addr_b  out  8 each  shared RAM addresses.
REQ-017 ram_we_a, ram_we_b  out  1 each  RAM write enables.
REQ-018 ram_wdata_a, ram_wdata_b  out  WIDTH each  RAM write data.
REQ-019 ram_rdata_a  in  WIDTH  RAM port A read data; 1-cycle read latency. Port B read data goes to the core directly.

Function
REQ-020 FSM states: IDLE, LOAD, RUN, RUN_REL, U_ADDR, U_WAIT, U_OUT, DONE.
REQ-021 IDLE->LOAD when start=1. cnt is cleared on this transition.
REQ-022 LOAD: in_ready=1. Each in_valid&in_ready cycle writes in_data to address cnt through port A, increments cnt. When cnt=N-1 is written, the FSM goes to RUN.
REQ-023 RUN: RAM ports A/B are driven combinationally from the core_* inputs. core_start is held at 1 until core_done=1 is sampled, then the FSM goes to RUN_REL.
REQ-024 RUN_REL: core_start=0 and the core mux stays selected. The FSM waits for core_done=0, then clears cnt and goes to U_ADDR.
REQ-025 U_ADDR: registers ram_addr_a=cnt with we=0, then goes to U_WAIT. U_WAIT then goes to U_OUT.
REQ-026 U_OUT: out_data is captured from ram_rdata_a on entry and held stable while out_valid=1.
REQ-027 In U_OUT, on out_ready the FSM goes to U_ADDR with cnt+1. At cnt=N-1 it goes to DONE instead.
REQ-028 Unload throughput is at most one word per 3 cycles.
REQ-029 DONE: done=1 for one cycle, then IDLE.
REQ-030 Outside RUN/RUN_REL, ram_we_b=0 and the core inputs are ignored.
REQ-031 Outside LOAD, in_ready=0. Outside U_OUT, out_valid=0.
REQ-032 start is ignored while busy=1. in_valid while not in LOAD is not consumed.
REQ-033 cnt is 9 bits. The RAM address is cnt[7:0]. No wrap occurs because termination is at N-1.
REQ-034 A core_done already high on RUN entry is honoured and releases immediately.

Reset
REQ-035 rst forces IDLE with cnt=0, busy=0, done=0, in_ready=0, out_valid=0, out_data=0, core_start=0, and all ram_* outputs 0.
REQ-036 rst asserted mid-job aborts at once with no further RAM writes. RAM contents are undefined afterwards, and the next job needs a fresh start.

Structure
REQ-037 Shared package holds Q=8380417, WIDTH, N, and the FSM state encoding.
REQ-038 Single module with no sub-module. The RAM mux is an inline combinational block keyed on state.

Verification
REQ-039 Load 256 words in_data=i with in_valid held high: in_ready for 256 cycles, RAM[i]=i, then core_start rises.
REQ-040 Stub core writes RAM[k]=k+100 and pulses core_done: core_start drops the cycle after core_done; unload yields out_data=k+100 for k=0..255, in order.
REQ-041 Load the vector x[i]=1 for i=0..255 and run the real INTT core: all 256 outputs match the golden model mod 8380417.
REQ-042 Randomly toggle in_valid and out_ready: no word is lost or duplicated, and out_data is stable while out_valid=1 and out_ready=0.
REQ-043 Assert rst during RUN at word 100: all outputs return to reset values the next edge, then a full job completes normally.
REQ-044 Pulse start while busy: it is ignored and exactly one done pulse occurs per job.

Source files
------------

// File: rtl/intt_seq_ctrl_pkg.sv
// Shared constants and FSM encoding for the INTT load/run/unload sequencer.
package intt_seq_ctrl_pkg;
  localparam int unsigned Q     = 8380417;
  localparam int          WIDTH = 24;
  localparam int          N     = 256;
  localparam int          AW    = 8;
  localparam int          CW    = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RUN_REL,
    S_U_ADDR,
    S_U_WAIT,
    S_U_OUT,
    S_DONE
  } state_e;
endpackage

// File: rtl/intt_seq_ctrl.sv
// Sequences one job: stream-load coefficients into a shared RAM, hand the RAM to
// the INTT core, then stream the result back out one word per three cycles.
module intt_seq_ctrl #(
  parameter int WIDTH = intt_seq_ctrl_pkg::WIDTH,
  parameter int N     = intt_seq_ctrl_pkg::N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             core_start,
  input  logic             core_done,
  input  logic [7:0]       core_addr_a,
  input  logic [7:0]       core_addr_b,
  input  logic             core_we_a,
  input  logic             core_we_b,
  input  logic [WIDTH-1:0] core_wdata_a,
  input  logic [WIDTH-1:0] core_wdata_b,
  output logic [7:0]       ram_addr_a,
  output logic [7:0]       ram_addr_b,
  output logic             ram_we_a,
  output logic             ram_we_b,
  output logic [WIDTH-1:0] ram_wdata_a,
  output logic [WIDTH-1:0] ram_wdata_b,
  input  logic [WIDTH-1:0] ram_rdata_a
);
  import intt_seq_ctrl_pkg::*;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (cnt_q == LAST) state_d = S_RUN;
          else               cnt_d   = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (core_done) state_d = S_RUN_REL;
      end
      S_RUN_REL: begin
        // wait for the core to drop done so a stale level can't retrigger it
        if (!core_done) begin
          cnt_d   = '0;
          state_d = S_U_ADDR;
        end
      end
      S_U_ADDR: state_d = S_U_WAIT;
      S_U_WAIT: begin
        out_data_d = ram_rdata_a;
        state_d    = S_U_OUT;
      end
      S_U_OUT: begin
        if (out_ready) begin
          if (cnt_q == LAST) state_d = S_DONE;
          else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_U_ADDR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign in_ready   = (state_q == S_LOAD);
  assign out_valid  = (state_q == S_U_OUT);
  assign core_start = (state_q == S_RUN);
  assign out_data   = out_data_q;

  // RAM port mux: loader, core, or unloader owns the ports depending on state
  always_comb begin
    ram_addr_a  = '0;
    ram_addr_b  = '0;
    ram_we_a    = 1'b0;
    ram_we_b    = 1'b0;
    ram_wdata_a = '0;
    ram_wdata_b = '0;
    case (state_q)
      S_LOAD: begin
        ram_addr_a  = cnt_q[AW-1:0];
        ram_we_a    = in_valid;
        ram_wdata_a = in_data;
      end
      S_RUN, S_RUN_REL: begin
        ram_addr_a  = core_addr_a;
        ram_addr_b  = core_addr_b;
        ram_we_a    = core_we_a;
        ram_we_b    = core_we_b;
        ram_wdata_a = core_wdata_a;
        ram_wdata_b = core_wdata_b;
      end
      S_U_ADDR, S_U_WAIT, S_U_OUT: ram_addr_a = cnt_q[AW-1:0];
      default: ;
    endcase
  end
endmodule

// File: tb/tb_intt_seq_ctrl.sv
// Directed bench: table of whole jobs against a RAM model and stub core, plus
// reset-abort and busy-start sequences.
module tb_intt_seq_ctrl;
  localparam int W = 24;

  typedef struct {
    int in_mul;
    int in_add;
    int core_add;
    bit in_stall;
    bit out_stall;
    bit early;
    bit start_busy;
    int exp_first;
    int exp_last;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         busy, done;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         core_start;
  logic         core_done = 1'b0;
  logic [7:0]   core_addr_a = '0, core_addr_b = '0;
  logic         core_we_a = 1'b0, core_we_b = 1'b0;
  logic [W-1:0] core_wdata_a = '0, core_wdata_b = '0;
  logic [7:0]   ram_addr_a, ram_addr_b;
  logic         ram_we_a, ram_we_b;
  logic [W-1:0] ram_wdata_a, ram_wdata_b;
  logic [W-1:0] ram_rdata_a = '0;
  logic [W-1:0] mem [0:255];

  int n_chk = 0, n_fail = 0, done_cnt = 0, jobs = 0;
  vec_t tbl [4];

  intt_seq_ctrl #(.WIDTH(W), .N(256)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_start(core_start), .core_done(core_done),
    .core_addr_a(core_addr_a), .core_addr_b(core_addr_b),
    .core_we_a(core_we_a), .core_we_b(core_we_b),
    .core_wdata_a(core_wdata_a), .core_wdata_b(core_wdata_b),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_wdata_a(ram_wdata_a), .ram_wdata_b(ram_wdata_b),
    .ram_rdata_a(ram_rdata_a)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_wdata_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_wdata_b;
    ram_rdata_a <= mem[ram_addr_a];
  end

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ld_val(input vec_t v, input int i);
    return W'(i * v.in_mul + v.in_add);
  endfunction

  // Leaves the caller at negedge+1 with the FSM in RUN.
  task automatic do_load(input vec_t v);
    int idx = 0, rdy = 0, cyc = 0, bad = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    while (idx < 256 && cyc < 2000) begin
      in_valid = v.in_stall ? ((cyc % 3) != 2) : 1'b1;
      in_data  = ld_val(v, idx);
      #1;
      if (in_ready) rdy++;
      if (in_valid && in_ready) idx++;
      @(negedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    #1;
    chk("load_words", idx, 256);
    if (!v.in_stall) chk("in_ready_cycles", rdy, 256);
    chk("in_ready_after_load", in_ready, 0);
    chk("core_start_rise", core_start, 1);
    for (int i = 0; i < 256; i++) if (mem[i] != ld_val(v, i)) bad++;
    chk("load_ram_contents", bad, 0);
  endtask

  task automatic job(input vec_t v);
    int n = 0, cyc = 0, bad = 0, stab = 0;
    logic held = 1'b0;
    logic [W-1:0] held_val = '0, exp;
    core_done = v.early;
    do_load(v);
    if (!v.early) begin
      if (v.start_busy) start = 1'b1;
      for (int k = 0; k < 256; k++) begin
        core_addr_a  = 8'(k);
        core_we_a    = 1'b1;
        core_wdata_a = W'(k + v.core_add);
        @(negedge clk); #1;
      end
      core_we_a = 1'b0;
      start     = 1'b0;
      core_done = 1'b1;
    end
    @(negedge clk); #1;
    chk("core_start_drop", core_start, 0);
    chk("busy_run_rel", busy, 1);
    core_done = 1'b0;
    while (n < 256 && cyc < 5000) begin
      out_ready = v.out_stall ? ((cyc % 4) == 3) : 1'b1;
      #1;
      if (out_valid) begin
        if (held && out_data != held_val) stab++;
        if (out_ready) begin
          exp = v.early ? ld_val(v, n) : W'(n + v.core_add);
          if (out_data != exp) begin
            if (bad == 0) $display("FAIL out_word[%0d]: got %0d expected %0d", n, out_data, exp);
            bad++;
          end
          if (n == 0)   chk("out_first", out_data, v.exp_first);
          if (n == 255) chk("out_last", out_data, v.exp_last);
          n++;
          held = 1'b0;
        end else begin
          held     = 1'b1;
          held_val = out_data;
        end
      end
      @(negedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    chk("out_words", n, 256);
    chk("out_word_errors", bad, 0);
    chk("out_data_stable", stab, 0);
    chk("done_pulse", done, 1);
    @(negedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    jobs++;
    chk("done_count", done_cnt, jobs);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_ram_we"}, {ram_we_a, ram_we_b}, 0);
    chk({tag, "_ram_addr"}, {ram_addr_a, ram_addr_b}, 0);
    chk({tag, "_ram_wdata"}, {ram_wdata_a, ram_wdata_b}, 0);
  endtask

  initial begin
    tbl[0] = '{1, 0,    100,     1'b0, 1'b0, 1'b0, 1'b0, 100,     355};
    tbl[1] = '{3, 5,    7,       1'b1, 1'b1, 1'b0, 1'b1, 7,       262};
    tbl[2] = '{1, 1000, 0,       1'b0, 1'b1, 1'b1, 1'b0, 1000,    1255};
    tbl[3] = '{2, 0,    8380000, 1'b1, 1'b0, 1'b0, 1'b0, 8380000, 8380255};

    @(negedge clk); #1;
    chk_reset_outputs("reset");
    @(negedge clk); rst = 1'b0;

    for (int r = 0; r < 4; r++) job(tbl[r]);

    // abort during the core phase at word 100: everything zero at once, no write lands
    core_done = 1'b0;
    do_load(tbl[0]);
    for (int k = 0; k < 100; k++) begin
      core_addr_a = 8'(k); core_we_a = 1'b1; core_wdata_a = W'(k + 100);
      @(negedge clk); #1;
    end
    core_addr_a = 8'd100; core_wdata_a = W'(200);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    @(negedge clk);
    chk("abort_no_write", mem[100], 100);
    core_we_a = 1'b0;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("abort_stays_idle", busy, 0);

    job(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
